// File: rtl/cond_pkg.sv
// ----------------------------------------------------------------------------
// cond_pkg
// Shared definitions for the conditional-execution slice:
//   - cond_e     : 4-bit instruction condition codes (EQ..AL, NV)
//   - FLAG_*     : bit positions of {N,Z,C,V} inside the 4-bit flag vectors
//   - FLAGW_*    : bit meanings of the 2-bit FlagW write mask
//   - SKIP_MAX   : saturation value of the squash counter
// ----------------------------------------------------------------------------
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111   // executes as AL
  } cond_e;

  // Flag bit positions within Flags / ALUFlags
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW bit meanings: [1] writes N,Z ; [0] writes C,V
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  localparam logic [15:0] SKIP_MAX = 16'hFFFF;

endpackage

// File: rtl/cond_logic_if.sv
// ----------------------------------------------------------------------------
// cond_logic_if
// Instruction-side bundle between the decoder (master) and the conditional
// logic (slave).
//   master drives : InstrValid, Cond, ALUFlags, FlagW, NoWrite, PCS, RegW, MemW
//   slave drives  : PCSrc, RegWrite, MemWrite, CondEx
// ----------------------------------------------------------------------------
interface cond_logic_if;

  logic       InstrValid;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       NoWrite;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;

  modport master (
    output InstrValid, Cond, ALUFlags, FlagW, NoWrite, PCS, RegW, MemW,
    input  PCSrc, RegWrite, MemWrite, CondEx
  );

  modport slave (
    input  InstrValid, Cond, ALUFlags, FlagW, NoWrite, PCS, RegW, MemW,
    output PCSrc, RegWrite, MemWrite, CondEx
  );

endinterface

// File: rtl/cond_check.sv
// ----------------------------------------------------------------------------
// cond_check
// Purely combinational condition evaluator.
//   Cond   in  4 : instruction condition field
//   Flags  in  4 : architectural {N,Z,C,V}
//   CondEx out 1 : condition passed
// ----------------------------------------------------------------------------
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;
  logic ge_s;

  assign n_s  = Flags[FLAG_N];
  assign z_s  = Flags[FLAG_Z];
  assign c_s  = Flags[FLAG_C];
  assign v_s  = Flags[FLAG_V];
  assign ge_s = (n_s == v_s);

  // Decode the condition field against the registered flags
  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      COND_EQ: CondEx = z_s;
      COND_NE: CondEx = ~z_s;
      COND_CS: CondEx = c_s;
      COND_CC: CondEx = ~c_s;
      COND_MI: CondEx = n_s;
      COND_PL: CondEx = ~n_s;
      COND_VS: CondEx = v_s;
      COND_VC: CondEx = ~v_s;
      COND_HI: CondEx = c_s & ~z_s;
      COND_LS: CondEx = ~c_s | z_s;
      COND_GE: CondEx = ge_s;
      COND_LT: CondEx = ~ge_s;
      COND_GT: CondEx = ~z_s & ge_s;
      COND_LE: CondEx = z_s | ~ge_s;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b1;   // 1111 behaves as AL
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// ----------------------------------------------------------------------------
// cond_logic
// Conditional-execution unit: gates decoder write intents with the condition
// result, holds the architectural {N,Z,C,V} register and optionally counts
// instructions squashed by their condition.
//
// Ports
//   clk       in   1  rising-edge clock
//   reset_n   in   1  asynchronous active-low reset
//   bus       slave   instruction-side bundle (see cond_logic_if)
//   SkipClr   in   1  synchronous clear of SkipCount
//   Flags     out  4  architectural {N,Z,C,V}
//   SkipCount out 16  saturating count of squashed valid instructions
//
// Build option
//   COND_SKIP_CNT_EN : when defined the squash counter exists; otherwise
//                      SkipCount is tied to zero and SkipClr is ignored.
// ----------------------------------------------------------------------------
module cond_logic
  import cond_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  cond_logic_if.slave  bus,
  input  logic         SkipClr,
  output logic [3:0]   Flags,
  output logic [15:0]  SkipCount
);

  logic       cond_ex_s;
  logic       exec_s;
  logic [3:0] flags_r;
  logic [3:0] flags_nxt_s;

  cond_check u_cond_check (
    .Cond   (bus.Cond),
    .Flags  (flags_r),
    .CondEx (cond_ex_s)
  );

  assign exec_s     = bus.InstrValid & cond_ex_s;
  assign bus.CondEx = cond_ex_s;
  assign Flags      = flags_r;

  // Zero-latency write-enable gating; held low while reset is asserted
  always_comb begin
    if (reset_n) begin
      bus.PCSrc    = bus.PCS  & exec_s;
      bus.MemWrite = bus.MemW & exec_s;
      bus.RegWrite = bus.RegW & exec_s & ~bus.NoWrite;
    end else begin
      bus.PCSrc    = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
    end
  end

  // Next flag value: N,Z and C,V pairs load independently
  always_comb begin
    flags_nxt_s = flags_r;
    if (exec_s & bus.FlagW[FLAGW_NZ]) begin
      flags_nxt_s[FLAG_N:FLAG_Z] = bus.ALUFlags[FLAG_N:FLAG_Z];
    end else begin
      flags_nxt_s[FLAG_N:FLAG_Z] = flags_r[FLAG_N:FLAG_Z];
    end
    if (exec_s & bus.FlagW[FLAGW_CV]) begin
      flags_nxt_s[FLAG_C:FLAG_V] = bus.ALUFlags[FLAG_C:FLAG_V];
    end else begin
      flags_nxt_s[FLAG_C:FLAG_V] = flags_r[FLAG_C:FLAG_V];
    end
  end

  // Architectural flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_r <= 4'b0000;
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

`ifdef COND_SKIP_CNT_EN
  logic [15:0] skip_r;
  logic [15:0] skip_nxt_s;

  // Squash counter next value: clear wins, increment saturates
  always_comb begin
    skip_nxt_s = skip_r;
    if (SkipClr) begin
      skip_nxt_s = 16'h0000;
    end else if (bus.InstrValid & ~cond_ex_s & (skip_r != SKIP_MAX)) begin
      skip_nxt_s = skip_r + 16'h0001;
    end else begin
      skip_nxt_s = skip_r;
    end
  end

  // Squash counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skip_r <= 16'h0000;
    end else begin
      skip_r <= skip_nxt_s;
    end
  end

  assign SkipCount = skip_r;
`else
  logic skip_clr_unused_s;

  assign skip_clr_unused_s = SkipClr;
  assign SkipCount         = 16'h0000;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// ----------------------------------------------------------------------------
// tb_cond_logic
// Directed self-checking bench for cond_logic. Inputs change 1 time unit after
// a rising edge; combinational outputs are checked 1 unit later and register
// results 1 unit after the following edge.
// ----------------------------------------------------------------------------
module tb_cond_logic;
  import cond_pkg::*;

`ifdef COND_SKIP_CNT_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        SkipClr;
  logic [3:0]  Flags;
  logic [15:0] SkipCount;

  cond_logic_if bus();

  cond_logic dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .SkipClr   (SkipClr),
    .Flags     (Flags),
    .SkipCount (SkipCount)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_skip;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] alu,
                       input logic [1:0] fw, input logic nw, input logic pcs,
                       input logic regw, input logic memw);
    bus.InstrValid = v;
    bus.Cond       = c;
    bus.ALUFlags   = alu;
    bus.FlagW      = fw;
    bus.NoWrite    = nw;
    bus.PCS        = pcs;
    bus.RegW       = regw;
    bus.MemW       = memw;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected effect of one squashed valid instruction on the counter
  task automatic bump_skip;
    if (exp_skip != 16'hFFFF) exp_skip = SKIP_EN ? exp_skip + 16'h0001 : 16'h0000;
  endtask

  // Load flags through an always-executed instruction
  task automatic load_flags(input logic [3:0] f);
    drive(1'b1, COND_AL, f, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // Sweep all 16 conditions as bubbles; bit i of exp_bits is CondEx for Cond=i
  task automatic run_table(input string tag, input logic [15:0] exp_bits);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i), 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
      #1;
      check_val($sformatf("%s_cond%0d", tag, i), {15'd0, bus.CondEx}, {15'd0, exp_bits[i]});
      tick();
    end
  endtask

  initial begin
    exp_skip = 16'h0000;
    SkipClr  = 1'b0;
    reset_n  = 1'b0;
    drive(1'b1, COND_AL, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_flags", {12'd0, Flags}, 16'h0000);
    check_val("rst_pcsrc", {15'd0, bus.PCSrc}, 16'h0000);
    check_val("rst_regwrite", {15'd0, bus.RegWrite}, 16'h0000);
    check_val("rst_memwrite", {15'd0, bus.MemWrite}, 16'h0000);
    check_val("rst_skip", SkipCount, 16'h0000);

    // Plain AL register write right after reset
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, COND_AL, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check_val("al_regwrite", {15'd0, bus.RegWrite}, 16'h0001);
    check_val("al_pcsrc", {15'd0, bus.PCSrc}, 16'h0000);
    check_val("al_flags", {12'd0, Flags}, 16'h0000);
    tick();

    // CMP equal, then BEQ taken on the new Z
    drive(1'b1, COND_AL, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check_val("cmp_nowrite", {15'd0, bus.RegWrite}, 16'h0000);
    tick();
    check_val("cmp_eq_flags", {12'd0, Flags}, 16'h0004);
    drive(1'b1, COND_EQ, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check_val("beq_taken_condex", {15'd0, bus.CondEx}, 16'h0001);
    check_val("beq_taken_pcsrc", {15'd0, bus.PCSrc}, 16'h0001);
    tick();

    // CMP not equal, then BEQ squashed
    drive(1'b1, COND_AL, 4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("cmp_ne_flags", {12'd0, Flags}, 16'h0000);
    drive(1'b1, COND_EQ, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    check_val("beq_nt_pcsrc", {15'd0, bus.PCSrc}, 16'h0000);
    check_val("beq_nt_memwrite", {15'd0, bus.MemWrite}, 16'h0000);
    tick();
    bump_skip();
    check_val("beq_nt_skip", SkipCount, exp_skip);

    // Partial update: N,Z held, C,V loaded
    load_flags(4'b1000);
    check_val("flags_1000", {12'd0, Flags}, 16'h0008);
    drive(1'b1, COND_AL, 4'b0011, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("flagw01", {12'd0, Flags}, 16'h000B);
    run_table("nzcv1011", 16'b1101_0101_0101_0110);
    check_val("bubble_hold", {12'd0, Flags}, 16'h000B);

    // Conditional store executes
    drive(1'b1, COND_AL, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check_val("al_memwrite", {15'd0, bus.MemWrite}, 16'h0001);
    tick();

    // Failed condition blocks register write and flag update
    load_flags(4'b0000);
    run_table("nzcv0000", 16'b1101_0110_1010_1010);
    drive(1'b1, COND_EQ, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check_val("squash_condex", {15'd0, bus.CondEx}, 16'h0000);
    check_val("squash_regwrite", {15'd0, bus.RegWrite}, 16'h0000);
    tick();
    bump_skip();
    check_val("squash_flags", {12'd0, Flags}, 16'h0000);
    check_val("squash_skip", SkipCount, exp_skip);

    load_flags(4'b0100);
    run_table("nzcv0100", 16'b1110_0110_1010_1001);

    // Only N,Z written
    drive(1'b1, COND_AL, 4'b1011, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("flagw10", {12'd0, Flags}, 16'h0008);

    // Reset pulse in the middle of a flag-writing instruction
    drive(1'b1, COND_AL, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    check_val("pre_rst_pcsrc", {15'd0, bus.PCSrc}, 16'h0001);
    reset_n = 1'b0;
    #1;
    check_val("midrst_flags", {12'd0, Flags}, 16'h0000);
    check_val("midrst_pcsrc", {15'd0, bus.PCSrc}, 16'h0000);
    check_val("midrst_regwrite", {15'd0, bus.RegWrite}, 16'h0000);
    check_val("midrst_memwrite", {15'd0, bus.MemWrite}, 16'h0000);
    tick();
    exp_skip = 16'h0000;
    check_val("midrst_edge_flags", {12'd0, Flags}, 16'h0000);
    check_val("midrst_skip", SkipCount, exp_skip);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, COND_AL, 4'b0010, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("post_rst_flags", {12'd0, Flags}, 16'h0002);

    // Squash counter: clear beats increment, then count again
    drive(1'b1, COND_EQ, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bump_skip();
    SkipClr = 1'b1;
    tick();
    SkipClr  = 1'b0;
    exp_skip = 16'h0000;
    check_val("clr_prio_skip", SkipCount, exp_skip);
    tick();
    bump_skip();
    check_val("count_after_clr", SkipCount, exp_skip);

`ifdef COND_SKIP_CNT_EN
    // Walk the counter up to saturation and one step beyond
    repeat (65534) @(posedge clk);
    #1;
    check_val("sat_reach", SkipCount, 16'hFFFF);
    tick();
    check_val("sat_hold", SkipCount, 16'hFFFF);
    SkipClr = 1'b1;
    tick();
    SkipClr = 1'b0;
    check_val("sat_clr", SkipCount, 16'h0000);
`endif

    drive(1'b0, COND_AL, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
